// File: rtl/ps2_cmd_arbiter.sv
// Round-robin arbiter sharing one PS/2 transmitter/receiver pair between two command requesters.
// Define PS2_ARB_RETRY_EN to re-send on FE or timeout, up to MAX_RETRY times.
module ps2_cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0_VALID,
  input  logic [7:0] REQ0_BYTE,
  input  logic       REQ1_VALID,
  input  logic [7:0] REQ1_BYTE,
  output logic       REQ0_DONE,
  output logic       REQ1_DONE,
  output logic [1:0] REQ_RESP,
  output logic [1:0] GRANT,
  output logic       BUSY,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY
);

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    SEND      = 5'b00010,
    WAIT_SENT = 5'b00100,
    WAIT_ACK  = 5'b01000,
    DONE      = 5'b10000
  } state_e;

  localparam logic [1:0]  RESP_ACK   = 2'b00;
  localparam logic [1:0]  RESP_NACK  = 2'b01;
  localparam logic [1:0]  RESP_TMO   = 2'b10;
  localparam logic [1:0]  RESP_RXERR = 2'b11;
  localparam logic [16:0] TMO_LAST   = 17'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  byte_q, byte_d;
  logic [1:0]  resp_q, resp_d;
  logic [16:0] timer_q, timer_d;
  logic        last_grant_q, last_grant_d;
  logic        send_q, send_d;
  logic        rd_en_q, rd_en_d;
  logic        busy_q, busy_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;

  logic        tmo;
  logic        win1;
  logic        retry_evt;
  logic [1:0]  evt_code;

`ifdef PS2_ARB_RETRY_EN
  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);
  logic [2:0] retry_q, retry_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = |3'(MAX_RETRY);
`endif

  assign tmo = (timer_q == TMO_LAST);

  // Next-state: arbitration, handshake sequencing and response decode
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    byte_d       = byte_q;
    resp_d       = resp_q;
    last_grant_d = last_grant_q;
    win1         = 1'b0;
    retry_evt    = 1'b0;
    evt_code     = RESP_NACK;
`ifdef PS2_ARB_RETRY_EN
    retry_d      = retry_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (REQ0_VALID || REQ1_VALID) begin
          // On a tie the requester that did not own the bus last time wins
          win1    = REQ1_VALID && (!REQ0_VALID || !last_grant_q);
          grant_d = win1 ? 2'b10 : 2'b01;
          byte_d  = win1 ? REQ1_BYTE : REQ0_BYTE;
          state_d = SEND;
`ifdef PS2_ARB_RETRY_EN
          retry_d = 3'd0;
`endif
        end
      end
      SEND: state_d = WAIT_SENT;
      WAIT_SENT: begin
        if (BYTE_SENT) begin
          state_d = WAIT_ACK;
        end else if (tmo) begin
          retry_evt = 1'b1;
          evt_code  = RESP_TMO;
        end
      end
      WAIT_ACK: begin
        if (BYTE_READY) begin
          if (BYTE_ERROR_CODE != 2'b00) begin
            state_d = DONE;
            resp_d  = RESP_RXERR;
          end else if (BYTE_READ == 8'hFA) begin
            state_d = DONE;
            resp_d  = RESP_ACK;
          end else if (BYTE_READ == 8'hFE) begin
            retry_evt = 1'b1;
            evt_code  = RESP_NACK;
          end else begin
            state_d = DONE;
            resp_d  = RESP_NACK;
          end
        end else if (tmo) begin
          retry_evt = 1'b1;
          evt_code  = RESP_TMO;
        end
      end
      DONE: begin
        last_grant_d = grant_q[1];
        grant_d      = 2'b00;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (retry_evt) begin
`ifdef PS2_ARB_RETRY_EN
      if (retry_q < RETRY_LIMIT) begin
        retry_d = retry_q + 3'd1;
        state_d = SEND;
      end else begin
        state_d = DONE;
        resp_d  = evt_code;
      end
`else
      state_d = DONE;
      resp_d  = evt_code;
`endif
    end
  end

  // Registered outputs are decoded from the next state so they align with it
  always_comb begin
    send_d  = (state_d == SEND);
    rd_en_d = (state_d == WAIT_SENT) || (state_d == WAIT_ACK);
    busy_d  = (state_d != IDLE);
    done0_d = (state_d == DONE) && grant_d[0];
    done1_d = (state_d == DONE) && grant_d[1];
    timer_d = 17'd0;
    if ((state_d == state_q) && rd_en_d) begin
      timer_d = timer_q + 17'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      byte_q       <= 8'hFF;
      resp_q       <= RESP_ACK;
      timer_q      <= 17'd0;
      last_grant_q <= 1'b1;
      send_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      byte_q       <= byte_d;
      resp_q       <= resp_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      send_q       <= send_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
    end
  end

`ifdef PS2_ARB_RETRY_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      retry_q <= 3'd0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign REQ0_DONE    = done0_q;
  assign REQ1_DONE    = done1_q;
  assign REQ_RESP     = resp_q;
  assign GRANT        = grant_q;
  assign BUSY         = busy_q;
  assign SEND_BYTE    = send_q;
  assign BYTE_TO_SEND = byte_q;
  assign READ_ENABLE  = rd_en_q;

endmodule
